// File: rtl/alu_serial_responder.sv
// Bit-serial ALU behind a request/response handshake: one 1-bit slice with a
// registered carry/borrow, LSB first, WIDTH compute cycles per operation.
module alu_serial_responder #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [WIDTH-1:0] i_req_a,
    input  logic [WIDTH-1:0] i_req_b,
    input  logic [1:0]       i_req_opcode,
    input  logic             i_req_cin,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [WIDTH-1:0] o_rsp_result,
    output logic             o_rsp_cout,
    output logic             o_rsp_zero
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_zero;
    logic             r_valid;

    logic             w_a;
    logic             w_b;
    logic             w_r;
    logic             w_c;
    logic [WIDTH-1:0] w_acc_next;

    // Single 1-bit slice; the accumulator keeps partial bits out of o_rsp_result.
    always_comb begin
        w_a        = r_a[r_cnt];
        w_b        = r_b[r_cnt];
        w_r        = 1'b0;
        w_c        = 1'b0;
        case (r_op)
            OP_ADD: begin
                w_r = w_a ^ w_b ^ r_carry;
                w_c = (w_a & w_b) | (r_carry & (w_a ^ w_b));
            end
            OP_SUB: begin
                w_r = w_a ^ w_b ^ r_carry;
                w_c = (~w_a & w_b) | (~w_a & r_carry) | (w_b & r_carry);
            end
            OP_AND:  w_r = w_a & w_b;
            OP_OR:   w_r = w_a | w_b;
            default: w_r = 1'b0;
        endcase
        w_acc_next        = r_acc;
        w_acc_next[r_cnt] = w_r;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= OP_ADD;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_zero   <= 1'b0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_a     <= i_req_a;
                        r_b     <= i_req_b;
                        r_op    <= i_req_opcode;
                        // Logic ops never see a carry, so cin is dropped here.
                        r_carry <= i_req_opcode[1] ? 1'b0 : i_req_cin;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_c;
                    if (r_cnt == LAST) begin
                        r_result <= w_acc_next;
                        r_cout   <= w_c;
                        r_zero   <= (w_acc_next == '0);
                        r_valid  <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_rsp_ready) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_req_ready  = (r_state == S_IDLE);
    assign o_rsp_valid  = r_valid;
    assign o_rsp_result = r_result;
    assign o_rsp_cout   = r_cout;
    assign o_rsp_zero   = r_zero;

endmodule

// File: tb/tb_alu_serial_responder.sv
// Randomized and directed bench for alu_serial_responder (WIDTH=4) against an
// arithmetic reference model.
module tb_alu_serial_responder;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic [1:0]   req_opcode = 2'b00;
    logic         req_cin = 1'b0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [W-1:0] rsp_result;
    logic         rsp_cout;
    logic         rsp_zero;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_serial_responder #(.WIDTH(W)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_a(req_a), .i_req_b(req_b), .i_req_opcode(req_opcode), .i_req_cin(req_cin),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_result(rsp_result), .o_rsp_cout(rsp_cout), .o_rsp_zero(rsp_zero)
    );

    // Reference: plain integer arithmetic modulo 2^W; borrow means a-b-cin < 0.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [1:0] op, input logic cin,
                                  output logic [W-1:0] r, output logic co);
        int s;
        case (op)
            2'b00: begin s = int'(a) + int'(b) + int'(cin); co = (s >= (1 << W)); end
            2'b01: begin s = int'(a) - int'(b) - int'(cin); co = (s < 0); end
            2'b10: begin s = int'(a & b); co = 1'b0; end
            default: begin s = int'(a | b); co = 1'b0; end
        endcase
        r = W'(s);
    endfunction

    // Present a request at a negedge, wait for acceptance, drop req_valid after the accept edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [1:0] op, input logic cin, output bit to);
        int n = 0;
        req_a = a; req_b = b; req_opcode = op; req_cin = cin; req_valid = 1'b1;
        while (!req_ready && n < 30) begin @(negedge clk); n++; end
        to = (n >= 30);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Count compute edges after accept until rsp_valid is seen at a negedge.
    task automatic wait_rsp(output int lat, output bit to);
        lat = 0;
        to  = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (rsp_valid) begin to = 1'b0; break; end
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] op, input logic cin,
                          output logic [W-1:0] r, output logic co, output logic z,
                          output int lat, output bit to);
        bit t1, t2;
        rsp_ready = 1'b1;
        issue(a, b, op, cin, t1);
        wait_rsp(lat, t2);
        to = t1 | t2;
        r = rsp_result; co = rsp_cout; z = rsp_zero;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({rsp_valid, req_ready, rsp_result, rsp_cout, rsp_zero} !== {1'b0, 1'b1, {W{1'b0}}, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset: valid=%b ready=%b result=%h cout=%b zero=%b, want 0 1 0 0 0",
                     rsp_valid, req_ready, rsp_result, rsp_cout, rsp_zero);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [W-1:0] ta[8] = '{4'd9, 4'd1, 4'd1, 4'd5, 4'd6, 4'hC, 4'hC, 4'd0};
        logic [W-1:0] tb[8] = '{4'd8, 4'd0, 4'd0, 4'd7, 4'd5, 4'hA, 4'hA, 4'd0};
        logic [1:0]   to_[8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11, 2'b00};
        logic         tc[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [W-1:0] er[8] = '{4'd1, 4'd1, 4'd1, 4'd14, 4'd0, 4'h8, 4'hE, 4'd0};
        logic         ec[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [W-1:0] r;
        logic co, z;
        int lat;
        bit to;
        for (int i = 0; i < 8; i++) begin
            run_op(ta[i], tb[i], to_[i], tc[i], r, co, z, lat, to);
            n_vec++;
            if (to || lat != W || r !== er[i] || co !== ec[i] || z !== (er[i] == 0)) begin
                n_err++;
                $display("FAIL directed[%0d]: timeout=%b lat=%0d result=%h cout=%b zero=%b, want lat=%0d result=%h cout=%b zero=%b",
                         i, to, lat, r, co, z, W, er[i], ec[i], (er[i] == 0));
            end
        end
    endtask

    task automatic test_truth;
        logic [W-1:0] a, b, er, r;
        logic ec, co, z;
        int lat;
        bit to;
        for (int p = 0; p < 8; p++) begin
            a = W'($urandom) & ~W'(1); a[0] = p[0];
            b = W'($urandom) & ~W'(1); b[0] = p[1];
            model(a, b, {1'b1, p[2]}, 1'b1, er, ec);
            run_op(a, b, {1'b1, p[2]}, 1'b1, r, co, z, lat, to);
            n_vec++;
            if (to || r !== er || co !== ec || z !== (er == 0)) begin
                n_err++;
                $display("FAIL truth op=%b a=%h b=%h: result=%h cout=%b zero=%b, want %h %b %b",
                         {1'b1, p[2]}, a, b, r, co, z, er, ec, (er == 0));
            end
        end
    endtask

    task automatic test_random;
        logic [W-1:0] a, b, er, r;
        logic [1:0] op;
        logic cin, ec, co, z;
        int lat;
        bit to;
        for (int i = 0; i < 40; i++) begin
            a = W'($urandom); b = W'($urandom); op = 2'($urandom); cin = 1'($urandom);
            model(a, b, op, cin, er, ec);
            run_op(a, b, op, cin, r, co, z, lat, to);
            n_vec++;
            if (to || lat != W || r !== er || co !== ec || z !== (er == 0)) begin
                n_err++;
                $display("FAIL random op=%b a=%h b=%h cin=%b: lat=%0d result=%h cout=%b zero=%b, want lat=%0d %h %b %b",
                         op, a, b, cin, lat, r, co, z, W, er, ec, (er == 0));
            end
        end
    endtask

    task automatic test_backpressure;
        logic [W-1:0] er;
        logic ec;
        int lat;
        bit t1, t2;
        model(4'd5, 4'd7, 2'b01, 1'b0, er, ec);
        rsp_ready = 1'b0;
        issue(4'd5, 4'd7, 2'b01, 1'b0, t1);
        wait_rsp(lat, t2);
        for (int k = 0; k < 5; k++) begin
            req_valid = 1'b1; req_a = 4'd3; req_b = 4'd3; req_opcode = 2'b00; req_cin = 1'b0;
            @(negedge clk);
            n_vec++;
            if (t1 || t2 || !rsp_valid || req_ready || rsp_result !== er || rsp_cout !== ec || rsp_zero !== 1'b0) begin
                n_err++;
                $display("FAIL backpressure[%0d]: valid=%b ready=%b result=%h cout=%b zero=%b, want 1 0 %h %b 0",
                         k, rsp_valid, req_ready, rsp_result, rsp_cout, rsp_zero, er, ec);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (rsp_valid || !req_ready) begin
            n_err++;
            $display("FAIL bp_retire: valid=%b ready=%b, want 0 1", rsp_valid, req_ready);
        end
        repeat (3) @(negedge clk);
        n_vec++;
        if (rsp_valid || !req_ready) begin
            n_err++;
            $display("FAIL bp_ignored_req: valid=%b ready=%b, want 0 1", rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid;
        logic [W-1:0] r;
        logic co, z;
        int lat;
        bit to, seen = 0;
        issue(4'd15, 4'd1, 2'b00, 1'b0, to);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (to || rsp_valid || !req_ready || rsp_result !== '0) begin
            n_err++;
            $display("FAIL reset_mid: valid=%b ready=%b result=%h, want 0 1 0", rsp_valid, req_ready, rsp_result);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        n_vec++;
        if (seen) begin
            n_err++;
            $display("FAIL reset_mid_no_rsp: response seen=%b, want 0", seen);
        end
        run_op(4'd3, 4'd4, 2'b00, 1'b0, r, co, z, lat, to);
        n_vec++;
        if (to || r !== 4'd7 || co !== 1'b0 || z !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid_next: result=%h cout=%b zero=%b, want 7 0 0", r, co, z);
        end
    endtask

    task automatic test_back_to_back;
        int acc_t[2];
        int n_acc = 0, n_rsp = 0;
        logic [W-1:0] res[2];
        logic cos[2];
        bit prev = 0, wide = 0;
        rsp_ready = 1'b1;
        req_a = 4'd9; req_b = 4'd12; req_opcode = 2'b00; req_cin = 1'b1; req_valid = 1'b1;
        for (int t = 0; t < 24; t++) begin
            if (rsp_valid) begin
                if (prev) wide = 1;
                if (n_rsp < 2) begin res[n_rsp] = rsp_result; cos[n_rsp] = rsp_cout; end
                n_rsp++;
            end
            prev = rsp_valid;
            if (req_valid && req_ready && n_acc < 2) begin acc_t[n_acc] = t; n_acc++; end
            @(posedge clk); #1;
            if (n_acc == 1) begin req_a = 4'd2; req_b = 4'd6; req_opcode = 2'b01; req_cin = 1'b0; end
            if (n_acc == 2) req_valid = 1'b0;
            @(negedge clk);
        end
        n_vec++;
        if (n_acc != 2 || acc_t[1] - acc_t[0] != W + 2) begin
            n_err++;
            $display("FAIL b2b_spacing: accepts=%0d gap=%0d, want 2 %0d", n_acc, acc_t[1] - acc_t[0], W + 2);
        end
        n_vec++;
        if (n_rsp != 2 || wide || res[0] !== 4'd6 || cos[0] !== 1'b1 || res[1] !== 4'd12 || cos[1] !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_rsp: count=%0d wide=%b r0=%h c0=%b r1=%h c1=%b, want 2 0 6 1 c 1",
                     n_rsp, wide, res[0], cos[0], res[1], cos[1]);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_truth();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_serial_responder.md
# alu_serial_responder

Bit-serial, handshaked ALU execution unit. It accepts an operation request (operands, opcode, carry-in), computes the result one bit per cycle through a single 1-bit ALU slice with a registered carry/borrow, and returns result, carry-out and zero flag on a response handshake. It uses the same 2-bit opcode map as the combinational ALUs. It sits behind a request/response interface, so an issuing block or bench can drive operations and collect results.

## Interface
- `WIDTH`, default 4: operand/result width in bits. Must be at least 1.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: unit can accept a request.
- `req_a` input WIDTH: operand A.
- `req_b` input WIDTH: operand B.
- `req_opcode` input 2: operation select.
  - 00 = ADD
  - 01 = SUB
  - 10 = AND
  - 11 = OR
- `req_cin` input 1: carry-in for ADD; borrow-in for SUB; ignored for AND/OR.
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: consumer takes the response.
- `rsp_result` output WIDTH: operation result.
- `rsp_cout` output 1: carry-out (ADD), borrow-out (SUB), 0 for AND/OR.
- `rsp_zero` output 1: 1 when `rsp_result` == 0.

## Operation
- States:
  - IDLE: `req_ready`=1.
  - BUSY: computes one bit per cycle.
  - DONE: `rsp_valid`=1.
- Accept rule: a request is accepted on a rising edge where `req_valid` && `req_ready`. `req_ready` = (state == IDLE), decoded combinationally from the state register.
- On accept:
  - Latch A, B, opcode.
  - Load the carry register with `req_cin` for ADD/SUB, or 0 for AND/OR.
  - Clear bit counter; state goes to BUSY.
- Each BUSY cycle processes bit i = counter, LSB first:
  - ADD: r = a^b^c; c' = (a&b)|(c&(a^b)).
  - SUB (a − b − c): r = a^b^c; c' = (~a&b)|(~a&c)|(b&c), i.e. the borrow.
  - AND: r = a&b; c' = 0.
  - OR: r = a|b; c' = 0.
- The r bit is written to result bit i; the carry register takes c'.
- When the counter reaches WIDTH−1, the next edge moves the state to DONE:
  - `rsp_result` = full result.
  - `rsp_cout` = final carry register.
  - `rsp_zero` is computed from the registered result.
- Arithmetic is modulo 2^WIDTH. `rsp_cout` is the only overflow indication; no signed overflow flag.
- DONE:
  - `rsp_result`, `rsp_cout` and `rsp_zero` hold stable while `rsp_valid` && !`rsp_ready`.
  - On an edge with `rsp_ready`=1, state goes to IDLE and `rsp_valid` drops.
- `req_valid` during BUSY/DONE is ignored (`req_ready`=0). The requester must hold the request until accepted.
- No same-cycle response-retire + request-accept. The earliest next accept is the cycle after returning to IDLE.
- Reset (asynchronous, any state, including mid-BUSY):
  - State goes to IDLE, counter 0, carry 0.
  - `rsp_result`=0, `rsp_cout`=0, `rsp_zero`=0, `rsp_valid`=0, `req_ready`=1 after reset.
  - Any in-flight operation is discarded with no response.

## Timing
- Accept edge E0. BUSY covers edges E1..E_WIDTH. `rsp_valid` rises after edge E_WIDTH: latency WIDTH cycles from accept to response.
- Minimum issue interval: WIDTH+2 cycles (accept, WIDTH compute edges, retire with `rsp_ready` held high, one IDLE cycle).
- `rsp_ready` may be high before `rsp_valid`. The response then retires on the first edge in DONE, so `rsp_valid` is high exactly one cycle.
- All outputs are registered except `req_ready`.
- Intermediate result bits are not visible: `rsp_result` updates only on entry to DONE. A separate shift/accumulate register holds the partial result.

## Test plan
All scenarios use WIDTH=4.
- ADD: a=9, b=8, cin=0 → after 4 cycles `rsp_valid`=1, result=1, cout=1, zero=0. ADD a=1, b=0, cin=0 → result=1, cout=0.
- SUB: a=1, b=0, cin=0 → result=1, cout=0. SUB a=5, b=7, cin=0 → result=14, cout=1. SUB a=6, b=5, cin=1 → result=0, cout=0, zero=1.
- AND: a=0xC, b=0xA → result=0x8, cout=0. OR: a=0xC, b=0xA, cin=1 → result=0xE, cout=0 (cin ignored). AND/OR of all four 1-bit patterns in bit 0 → correct truth table.
- Backpressure: hold `rsp_ready`=0 for 5 cycles after `rsp_valid` → all outputs stable, `req_ready`=0. A new `req_valid` with different operands during this window is not accepted. Raising `rsp_ready` → retire next edge, `req_ready`=1 one cycle later.
- Reset mid-operation: assert `rst` asynchronously during the 2nd BUSY cycle of ADD 15+1 → immediately `rsp_valid`=0, `req_ready`=1, `rsp_result`=0. No response appears afterwards. A following ADD 3+4 yields 7, cout=0.
- Back-to-back: two requests with `rsp_ready` tied high → accepts exactly WIDTH+2 cycles apart, each `rsp_valid` high for exactly one cycle, correct results in order.
